mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipelined core's fetch port (IF) and load/store port (MEM).
- Serialises the two ports' requests and issues them to the memory with a request/acknowledge handshake.
- Returns read data and a one-cycle ready pulse to the port that was granted.
- Sits between the core datapath (PCF/InstrF, ALUResultM/WriteDataM/MemDataM) and the memory. The hazard logic converts a requester's pending-and-not-ready condition into StallF or a full-pipeline stall.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while IF is waiting before IF is forced a grant. Range 1..15.
- TIMEOUT, 16: cycles to wait for mem_ack before the transaction is aborted with an error. Range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch word address (byte address, [1:0] ignored).
- if_rdata  out  32  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- if_err  out  1  fetch timed out; valid with if_ready.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_rdata  out  32  load data; valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the data port.
- d_err  out  1  data access timed out; valid with d_ready.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; may assert in any cycle in which mem_req=1, including the first.

Behaviour:

States: IDLE, BUSY, RESP. Reset drives state to IDLE immediately (asynchronous). Reset values of all outputs: 0. Streak counter resets to 0.

IDLE:
- Samples requests.
- Data port has priority, except when the streak counter equals MAX_D_STREAK and if_req=1; then IF wins.
- On a grant: register the request fields and the granted port into the mem_* output registers, set mem_req=1 from the next cycle, clear the timer, go to BUSY.
- With no request: stay in IDLE, mem_req=0.

Streak counter:
- +1 on each data grant made while if_req=1.
- Cleared on any IF grant, and on a data grant made while if_req=0.
- Saturates at MAX_D_STREAK.

BUSY:
- mem_* outputs are held stable while mem_req=1. IF grants drive mem_we=0 and mem_be=4'hF.
- The timer increments each cycle.
- On mem_ack=1: capture mem_rdata into the granted port's rdata register, drop mem_req, go to RESP with err=0.
- If the timer reaches TIMEOUT-1 without an ack: drop mem_req, go to RESP with err=1 and rdata=0.

RESP:
- The granted port's ready=1 for exactly one cycle; err is shown alongside.
- Go to IDLE. New requests are not sampled in RESP; this prevents re-granting a request that is still held during its own ready cycle.

Latency:
- Request sampled in IDLE at cycle 0, mem_req high at cycle 1.
- With ack in cycle 1: ready at cycle 2; the earliest next grant is sampled at cycle 3.
- Minimum: 3 cycles per access, back to back.

Requester rules:
- A requester deasserting req mid-transaction does not abort it; the ready pulse still occurs.
- rdata holds its value until that port's next ready.

Other rules:
- Simultaneous if_req and d_req in IDLE: data wins unless the streak limit applies.
- The port that was not granted sees no ready.
- A mem_ack outside BUSY is ignored.
- Reset during BUSY or RESP: mem_req and ready drop asynchronously, and no ready pulse is produced for the aborted transaction.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2;
  - grant ids GNT_IF=1'b0, GNT_D=1'b1;
  - the default values of MAX_D_STREAK and TIMEOUT.
- One sub-module, arb_timeout_ctr: a clearable up-counter with a terminal-count flag, parameterised by TIMEOUT.

Test Plan:
- Single load: d_req=1, d_we=0, d_addr=0x100; mem_ack at cycle 1 with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; d_ready=1 and d_rdata=0xDEADBEEF at cycle 2; d_err=0.
- Simultaneous requests: if_req (0x40) and d_req store (0x200, 0x12345678, be=4'b0011) with immediate acks -> data served first (mem_we=1, mem_be=4'b0011), then fetch of 0x40 with mem_be=4'hF; if_ready 3 cycles after d_ready.
- Starvation limit: MAX_D_STREAK=4, d_req and if_req held high continuously -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Timeout: TIMEOUT=16, d_req with mem_ack held 0 -> mem_req high for exactly 16 cycles, then d_ready=1 with d_err=1 and d_rdata=0.
- Reset mid-operation: assert reset during BUSY -> mem_req and all ready signals 0 in the same cycle, state IDLE; after release, a new fetch completes normally.
- Wait states plus dropped request: fetch with ack delayed 5 cycles and if_req dropped at cycle 2 -> mem_addr held stable, if_ready still pulses once, no extra grant follows.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package : mem_arb_pkg
// Brief   : Shared encodings and defaults for the IF/MEM memory port arbiter.
// Rev     : 1.0 - initial release
//==============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arbState_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    localparam int c_defMaxDStreak = 4;
    localparam int c_defTimeout    = 16;

    localparam logic [3:0] c_fetchBe = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_timeout_ctr.sv
`default_nettype none
//==============================================================================
// Module : arb_timeout_ctr
// Brief  : Clearable up-counter flagging the last cycle of the ack window.
// Rev    : 1.0 - initial release
//==============================================================================
module arb_timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = c_defTimeout
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int c_width = $clog2(TIMEOUT);
    localparam logic [c_width-1:0] c_last = c_width'(TIMEOUT - 1);

    logic [c_width-1:0] r_count;

    // Holds at the terminal value so the flag never wraps back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module : mem_port_arbiter
// Brief  : Serialises fetch and load/store requests onto one shared memory.
// Rev    : 1.0 - initial release
//==============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = c_defMaxDStreak,
    parameter int TIMEOUT      = c_defTimeout
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [3:0] c_streakMax = 4'(MAX_D_STREAK);

    arbState_t   r_state;
    arbState_t   w_stateNext;
    logic        w_grant;
    logic        w_gntSel;
    logic        w_finish;
    logic        w_busy;
    logic        w_timeoutTc;
    logic        w_unusedIfAddr;

    logic        r_gnt;
    logic [3:0]  r_dStreak;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [3:0]  r_memBe;
    logic [31:0] r_ifRdata;
    logic [31:0] r_dRdata;
    logic        r_ifReady;
    logic        r_dReady;
    logic        r_ifErr;
    logic        r_dErr;

    // Fetches are word aligned; the byte offset bits are dropped.
    assign w_unusedIfAddr = ^if_addr[1:0];
    assign w_busy         = (r_state == ST_BUSY);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeoutCtr (
        .clk   (clk),
        .reset (reset),
        .clr   (w_grant),
        .en    (w_busy),
        .tc    (w_timeoutTc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_grant     = 1'b0;
        w_gntSel    = GNT_D;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    w_grant     = 1'b1;
                    w_stateNext = ST_BUSY;
                    // Data normally wins; a starved fetch is forced through.
                    if (if_req && (!d_req || (r_dStreak == c_streakMax))) begin
                        w_gntSel = GNT_IF;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack || w_timeoutTc) begin
                    w_finish    = 1'b1;
                    w_stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt      <= GNT_IF;
            r_dStreak  <= '0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memBe    <= '0;
            r_ifRdata  <= '0;
            r_dRdata   <= '0;
            r_ifReady  <= 1'b0;
            r_dReady   <= 1'b0;
            r_ifErr    <= 1'b0;
            r_dErr     <= 1'b0;
        end else begin
            r_ifReady <= 1'b0;
            r_dReady  <= 1'b0;
            r_ifErr   <= 1'b0;
            r_dErr    <= 1'b0;

            if (w_grant) begin
                r_gnt    <= w_gntSel;
                r_memReq <= 1'b1;
                if (w_gntSel == GNT_D) begin
                    r_memWe    <= d_we;
                    r_memAddr  <= d_addr;
                    r_memWdata <= d_wdata;
                    r_memBe    <= d_be;
                    if (!if_req) begin
                        r_dStreak <= '0;
                    end else if (r_dStreak != c_streakMax) begin
                        r_dStreak <= r_dStreak + 4'd1;
                    end
                end else begin
                    r_memWe    <= 1'b0;
                    r_memAddr  <= {if_addr[31:2], 2'b00};
                    r_memWdata <= '0;
                    r_memBe    <= c_fetchBe;
                    r_dStreak  <= '0;
                end
            end

            // An ack in the terminal cycle still counts as a good completion.
            if (w_finish) begin
                r_memReq <= 1'b0;
                if (r_gnt == GNT_D) begin
                    r_dReady <= 1'b1;
                    r_dErr   <= !mem_ack;
                    r_dRdata <= mem_ack ? mem_rdata : 32'h0;
                end else begin
                    r_ifReady <= 1'b1;
                    r_ifErr   <= !mem_ack;
                    r_ifRdata <= mem_ack ? mem_rdata : 32'h0;
                end
            end
        end
    end

    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_be    = r_memBe;
    assign if_rdata  = r_ifRdata;
    assign if_ready  = r_ifReady;
    assign if_err    = r_ifErr;
    assign d_rdata   = r_dRdata;
    assign d_ready   = r_dReady;
    assign d_err     = r_dErr;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench for mem_port_arbiter (vectors, sequences, random).
// Rev    : 1.0 - initial release
//==============================================================================
module tb_mem_port_arbiter;

    localparam int c_maxD    = 4;
    localparam int c_timeout = 16;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_port_arbiter #(
        .MAX_D_STREAK (c_maxD),
        .TIMEOUT      (c_timeout)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One single-transaction vector: stimulus, memory behaviour, expected results.
    typedef struct {
        logic        isD;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ackAt;       // BUSY cycle carrying the ack, 0 = never
        logic [31:0] memData;
        logic [31:0] expAddr;
        logic        expWe;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        int          expReqCycles;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[7];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } gnt_t;

    gnt_t gq[$];
    int   ifRdyCyc[$];
    int   dRdyCyc[$];
    int   cycle;
    logic prevReq;

    task automatic doReset();
        @(negedge clk);
        reset   = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        cycle   = 0;
        prevReq = 1'b0;
    endtask

    task automatic tick(input bit autoAck, input bit dropOnReady);
        @(negedge clk);
        cycle++;
        if (mem_req && !prevReq) gq.push_back('{mem_addr, mem_we, mem_be, mem_wdata, cycle});
        if (if_ready) begin
            ifRdyCyc.push_back(cycle);
            if (dropOnReady) if_req = 1'b0;
        end
        if (d_ready) begin
            dRdyCyc.push_back(cycle);
            if (dropOnReady) d_req = 1'b0;
        end
        prevReq   = mem_req;
        mem_ack   = autoAck & mem_req;
        mem_rdata = $urandom;
    endtask

    task automatic runVec(input vec_t v);
        int cyc  = 0;
        bit seen = 0;
        if (v.isD) begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_be    = v.be;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        @(negedge clk);
        for (int g = 0; g < 40 && !seen; g++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                cyc++;
                chk("vec_addr", 64'(mem_addr), 64'(v.expAddr));
                if (cyc == 1) begin
                    chk("vec_we", 64'(mem_we), 64'(v.expWe));
                    chk("vec_be", 64'(mem_be), 64'(v.expBe));
                    if (v.isD) chk("vec_wdata", 64'(mem_wdata), 64'(v.expWdata));
                end
                if (cyc == v.ackAt) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.memData;
                end
            end else if (cyc > 0) begin
                seen = 1;
                chk("vec_req_cycles", 64'(cyc), 64'(v.expReqCycles));
                chk("vec_ready", 64'({d_ready, if_ready}), v.isD ? 64'd2 : 64'd1);
                chk("vec_err", 64'(v.isD ? d_err : if_err), 64'(v.expErr));
                chk("vec_rdata", 64'(v.isD ? d_rdata : if_rdata), 64'(v.expRdata));
            end
            if (!seen) @(negedge clk);
        end
        if (!seen) chk("vec_completion_seen", 64'd0, 64'd1);
        if_req  = 1'b0;
        d_req   = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("vec_single_pulse", 64'({if_ready, d_ready}), 64'd0);
    endtask

    // Reference model state for the randomized phase.
    localparam int P_SAMPLE = 0;
    localparam int P_BUSY   = 1;
    localparam int P_DONE   = 2;
    localparam int P_GAP    = 3;

    int          phase;
    int          busyCnt;
    int          ackAt;
    int          streak;
    bit          curD;
    bit          expErr;
    bit          busyNow;
    logic [31:0] expData;
    logic [31:0] lastIf;
    logic [31:0] lastD;

    task automatic busyStep();
        busyNow = 1;
        busyCnt++;
        chk("rnd_memreq_busy", 64'(mem_req), 64'd1);
        chk("rnd_addr_hold", 64'(mem_addr), 64'(curD ? d_addr : if_addr));
        if (busyCnt == ackAt) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            expData   = mem_rdata;
            expErr    = 0;
            phase     = P_DONE;
        end else if (busyCnt == c_timeout) begin
            expData = 32'h0;
            expErr  = 1;
            phase   = P_DONE;
        end
    endtask

    int expPat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1, 32'hDEADBEEF,
                    32'h100, 1'b0, 4'hF, 32'h0, 1, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 4'h3, 3, 32'h11111111,
                    32'h204, 1'b1, 4'h3, 32'hCAFEF00D, 3, 1'b0, 32'h11111111};
        vecs[2] = '{1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 2, 32'h00A00093,
                    32'h40, 1'b0, 4'hF, 32'h0, 2, 1'b0, 32'h00A00093};
        vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 0, 32'h0,
                    32'h300, 1'b0, 4'hF, 32'h0, 16, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h308, 32'hA5A5A5A5, 4'hC, 16, 32'h5A5A5A5A,
                    32'h308, 1'b1, 4'hC, 32'hA5A5A5A5, 16, 1'b0, 32'h5A5A5A5A};
        vecs[5] = '{1'b0, 1'b0, 32'h84, 32'h0, 4'h0, 0, 32'h0,
                    32'h84, 1'b0, 4'hF, 32'h0, 16, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h88, 32'h0, 4'h0, 15, 32'h13579BDF,
                    32'h88, 1'b0, 4'hF, 32'h0, 15, 1'b0, 32'h13579BDF};

        // Reset state
        @(negedge clk);
        chk("rst_flags", 64'({if_ready, if_err, d_ready, d_err, mem_req, mem_we}), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_mem_bus", 64'({mem_addr, mem_be}), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) runVec(vecs[i]);

        // Simultaneous requests: data first, fetch three cycles later
        doReset();
        gq.delete(); ifRdyCyc.delete(); dRdyCyc.delete();
        if_req  = 1'b1; if_addr = 32'h40;
        d_req   = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'b0011;
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b1);
        chk("sim_grants", 64'(gq.size()), 64'd2);
        if (gq.size() >= 2) begin
            chk("sim_first_addr", 64'(gq[0].addr), 64'h200);
            chk("sim_first_we_be", 64'({gq[0].we, gq[0].be}), 64'h13);
            chk("sim_first_wdata", 64'(gq[0].wdata), 64'h12345678);
            chk("sim_second_addr", 64'(gq[1].addr), 64'h40);
            chk("sim_second_we_be", 64'({gq[1].we, gq[1].be}), 64'h0F);
        end
        chk("sim_ready_counts", 64'({ifRdyCyc.size(), dRdyCyc.size()}), {32'd1, 32'd1});
        if (ifRdyCyc.size() == 1 && dRdyCyc.size() == 1)
            chk("sim_ready_gap", 64'(ifRdyCyc[0] - dRdyCyc[0]), 64'd3);

        // Starvation limit with both requests held continuously
        doReset();
        gq.delete(); ifRdyCyc.delete(); dRdyCyc.delete();
        if_req  = 1'b1; if_addr = 32'h40;
        d_req   = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        for (int k = 0; k < 32; k++) tick(1'b1, 1'b0);
        if_req = 1'b0; d_req = 1'b0;
        chk("starve_grant_count", 64'(gq.size() >= 10), 64'd1);
        for (int k = 0; k < 10 && k < gq.size(); k++)
            chk($sformatf("starve_grant_%0d", k), 64'(gq[k].addr), expPat[k] != 0 ? 64'h200 : 64'h40);

        // Reset during BUSY aborts without a ready pulse
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        if_req = 1'b1; if_addr = 32'h44;
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
        chk("rstmid_in_busy", 64'(mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_memreq", 64'(mem_req), 64'd0);
        chk("rstmid_ready", 64'({if_ready, d_ready}), 64'd0);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prevReq = 1'b0;
        gq.delete(); ifRdyCyc.delete(); dRdyCyc.delete();
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0);
        chk("rstmid_no_activity", 64'({gq.size(), ifRdyCyc.size() + dRdyCyc.size()}), 64'd0);
        runVec(vecs[2]);

        // Wait states with the fetch request dropped mid-transaction
        gq.delete(); ifRdyCyc.delete(); dRdyCyc.delete();
        cycle = 0; prevReq = 1'b0;
        if_req = 1'b1; if_addr = 32'h88;
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0);
            if (mem_req) chk("wait_addr_hold", 64'(mem_addr), 64'h88);
            if (if_ready) chk("wait_rdata", 64'(if_rdata), 64'h0BADF00D);
            if (cycle == 1) if_req = 1'b0;
            if (cycle == 6) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BADF00D;
            end
        end
        chk("wait_grants", 64'(gq.size()), 64'd1);
        chk("wait_ready_count", 64'(ifRdyCyc.size()), 64'd1);
        if (ifRdyCyc.size() == 1) chk("wait_ready_cycle", 64'(ifRdyCyc[0]), 64'd7);

        // Randomized traffic against the transaction-level model
        doReset();
        phase  = P_SAMPLE;
        streak = 0;
        lastIf = 32'h0;
        lastD  = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            busyNow = 0;
            if (phase != P_DONE) chk("rnd_no_ready", 64'({if_ready, d_ready}), 64'd0);
            case (phase)
                P_SAMPLE: begin
                    if (if_req || d_req) begin
                        curD = d_req && !(if_req && streak >= c_maxD);
                        if (curD) begin
                            chk("rnd_grant_d", 64'({mem_we, mem_be, mem_addr}), 64'({d_we, d_be, d_addr}));
                            chk("rnd_grant_wdata", 64'(mem_wdata), 64'(d_wdata));
                            streak = if_req ? ((streak < c_maxD) ? streak + 1 : streak) : 0;
                        end else begin
                            chk("rnd_grant_if", 64'({mem_we, mem_be, mem_addr}), 64'({1'b0, 4'hF, if_addr}));
                            streak = 0;
                        end
                        ackAt   = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 6);
                        busyCnt = 0;
                        phase   = P_BUSY;
                        busyStep();
                    end else begin
                        chk("rnd_idle_noreq", 64'(mem_req), 64'd0);
                    end
                end
                P_BUSY: busyStep();
                P_DONE: begin
                    chk("rnd_done_memreq", 64'(mem_req), 64'd0);
                    if (curD) begin
                        chk("rnd_done_ready_d", 64'({d_ready, if_ready}), 64'd2);
                        chk("rnd_done_err_d", 64'(d_err), 64'(expErr));
                        chk("rnd_done_rdata_d", 64'(d_rdata), 64'(expData));
                        chk("rnd_hold_rdata_if", 64'(if_rdata), 64'(lastIf));
                        lastD = expData;
                        d_req = 1'b0;
                    end else begin
                        chk("rnd_done_ready_if", 64'({d_ready, if_ready}), 64'd1);
                        chk("rnd_done_err_if", 64'(if_err), 64'(expErr));
                        chk("rnd_done_rdata_if", 64'(if_rdata), 64'(expData));
                        chk("rnd_hold_rdata_d", 64'(d_rdata), 64'(lastD));
                        lastIf = expData;
                        if_req = 1'b0;
                    end
                    phase = P_GAP;
                end
                default: begin
                    chk("rnd_gap_memreq", 64'(mem_req), 64'd0);
                    phase = P_SAMPLE;
                end
            endcase
            if (!busyNow && $urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
